// File: rtl/gesture_uart_reporter.sv
// Gesture event FIFO feeding an 8N1 UART packet transmitter.
// Define GESTURE_REPORT_CHECKSUM_EN to append an XOR checksum byte to each packet.
module gesture_uart_reporter #(
    parameter int CLK_FREQ_HZ = 12000000,
    parameter int BAUD        = 115200,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [1:0]                    gesture,
    input  logic                          gesture_valid,
    input  logic [3:0]                    gesture_confidence,
    output logic                          uart_tx,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [7:0]                    drop_count
);

    // state | meaning
    // IDLE  | line high, pops the FIFO head when one is queued
    // START | start bit (low) for one bit period
    // DATA  | eight data bits, LSB first
    // STOP  | stop bit (high); then next byte or back to IDLE

    localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD;
    localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int AW           = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int LW           = AW + 1;
`ifdef GESTURE_REPORT_CHECKSUM_EN
    localparam int NUM_BYTES    = 3;
`else
    localparam int NUM_BYTES    = 2;
`endif

    localparam logic [LW-1:0]    LEVEL_FULL = LW'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] BAUD_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [1:0]       BYTE_LAST  = 2'(NUM_BYTES - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    logic [5:0]       mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    level;
    logic [7:0]       drops;
    logic [5:0]       head;
    logic             fifo_empty;
    logic             fifo_full;
    logic             pop;
    logic             push;
    logic             drop;

    logic [1:0]       state;
    logic             tx_q;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_idx;
    logic [1:0]       byte_idx;
    logic [3:0]       seq;
    logic [7:0]       shift;
    logic [3:0]       pkt_conf;
    logic [7:0]       byte1;
    logic [7:0]       next_byte;
    logic             baud_done;
`ifdef GESTURE_REPORT_CHECKSUM_EN
    logic [1:0]       pkt_gesture;
    logic [7:0]       byte0;
`endif

    assign fifo_empty = (level == '0);
    assign fifo_full  = (level == LEVEL_FULL);
    assign pop        = (state == ST_IDLE) && !fifo_empty;
    // A push into a full FIFO survives when the head leaves on the same edge.
    assign push       = gesture_valid && (!fifo_full || pop);
    assign drop       = gesture_valid && fifo_full && !pop;
    assign head       = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {gesture, gesture_confidence};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            drops  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
            if (drop && (drops != 8'hFF)) begin
                drops <= drops + 8'd1;
            end
        end
    end

    assign byte1     = {pkt_conf, seq};
    assign baud_done = (baud_cnt == BAUD_LAST);

`ifdef GESTURE_REPORT_CHECKSUM_EN
    assign byte0 = {4'hA, 2'b00, pkt_gesture};

    always_comb begin
        next_byte = byte1;
        if (byte_idx != 2'd0) begin
            next_byte = byte0 ^ byte1;
        end
    end
`else
    always_comb begin
        next_byte = byte1;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            tx_q     <= 1'b1;
            baud_cnt <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
            seq      <= '0;
            shift    <= '0;
            pkt_conf <= '0;
`ifdef GESTURE_REPORT_CHECKSUM_EN
            pkt_gesture <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    tx_q <= 1'b1;
                    if (!fifo_empty) begin
                        pkt_conf <= head[3:0];
`ifdef GESTURE_REPORT_CHECKSUM_EN
                        pkt_gesture <= head[5:4];
`endif
                        shift    <= {4'hA, 2'b00, head[5:4]};
                        byte_idx <= '0;
                        baud_cnt <= '0;
                        tx_q     <= 1'b0;
                        state    <= ST_START;
                    end
                end
                ST_START: begin
                    if (baud_done) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        tx_q     <= shift[0];
                        state    <= ST_DATA;
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end
                ST_DATA: begin
                    if (baud_done) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            tx_q  <= 1'b1;
                            state <= ST_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx_q    <= shift[1];
                            shift   <= {1'b0, shift[7:1]};
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end
                ST_STOP: begin
                    if (baud_done) begin
                        baud_cnt <= '0;
                        if (byte_idx == BYTE_LAST) begin
                            seq   <= seq + 4'd1;
                            tx_q  <= 1'b1;
                            state <= ST_IDLE;
                        end else begin
                            byte_idx <= byte_idx + 2'd1;
                            shift    <= next_byte;
                            tx_q     <= 1'b0;
                            state    <= ST_START;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    tx_q  <= 1'b1;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign uart_tx    = tx_q;
    assign tx_busy    = (state != ST_IDLE);
    assign fifo_level = level;
    assign drop_count = drops;

endmodule

// File: doc/gesture_uart_reporter.md
Name: gesture_uart_reporter

Overview:
- Consumer end of the classifier output interface. Each single-cycle gesture event (gesture code + confidence) is captured in a small event FIFO.
- Each event is serialized as a fixed-format packet on an 8N1 UART TX line to the host.
- Sits between the gesture classifier and the board UART pin; only path by which confirmed gestures leave the FPGA.

Parameters:
- CLK_FREQ_HZ, 12000000, system clock frequency.
- BAUD, 115200, UART bit rate; CLKS_PER_BIT = CLK_FREQ_HZ / BAUD, integer truncation, must be >= 4.
- FIFO_DEPTH, 4, event FIFO entries; power of two, 2..16.

Ports:
- clk  input  1  system clock, single clock domain.
- rst  input  1  synchronous, active-high reset.
- gesture  input  2  gesture code, valid only with gesture_valid.
- gesture_valid  input  1  one-cycle event strobe.
- gesture_confidence  input  4  confidence, valid only with gesture_valid.
- uart_tx  output  1  serial line, idle high.
- tx_busy  output  1  high while a packet is being shifted out, start bit through last stop bit.
- fifo_level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- drop_count  output  8  saturating count of events lost to FIFO full.

Behaviour:
- Reset values: uart_tx=1, tx_busy=0, fifo_level=0, drop_count=0.
- Reset also clears: FIFO, packet sequence counter seq[3:0], baud counter, bit index; FSM goes to IDLE.
- Reset mid-frame aborts the frame. uart_tx is high on the cycle after rst is sampled.

FIFO:
- On gesture_valid, {gesture, gesture_confidence} (6 bits) is written at that clock edge.
- When full, the event is dropped and drop_count increments, saturating at 255.
- A pop and a push in the same cycle while full: the push is accepted, level unchanged, no drop.
- Push while empty and FSM IDLE: the entry is still written; no bypass path.

Packet format (bytes sent LSB first):
- byte0 = {4'hA, 2'b00, gesture}.
- byte1 = {confidence, seq}.
- seq increments by 1 after each packet's final stop bit; wraps 15->0.

FSM states:
- IDLE: uart_tx=1. If the FIFO is non-empty, pop the head into the packet register, load byte0, go to START.
- START: uart_tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index=0.
- DATA: uart_tx=shift[bit index] for CLKS_PER_BIT cycles per bit. After bit 7, go to STOP.
- STOP: uart_tx=1 for CLKS_PER_BIT cycles. Then, if more bytes remain in the packet, load the next byte and go to START; else bump seq and go to IDLE.

Timing:
- Latency: with gesture_valid high in cycle N and FIFO empty and IDLE, the FIFO write occurs at edge N and the pop at edge N+1.
- uart_tx is first low in cycle N+2 (the cycle after the N+1 edge); tx_busy rises in the same cycle.
- Packet duration is 2 x 10 x CLKS_PER_BIT cycles, with no idle gap between bytes.
- tx_busy falls in the first cycle after the final stop bit's last cycle.
- A new packet may start on the cycle after a return to IDLE, giving a minimum 1-cycle idle-high gap between packets.

Baud counter:
- Counts 0..CLKS_PER_BIT-1 and is reloaded on every state or bit transition.
- Each bit is held exactly CLKS_PER_BIT cycles.

Optional Feature:
- Macro: GESTURE_REPORT_CHECKSUM_EN.
- When defined: a third byte, byte2 = byte0 XOR byte1, is sent after byte1. Packet length is 3 bytes (30 x CLKS_PER_BIT cycles); seq increments after byte2's stop bit.
- When undefined: 2-byte packet as above, and no checksum logic is present.

Test Plan:
- Single event, CLK_FREQ_HZ=1000, BAUD=100 (CLKS_PER_BIT=10): gesture=2'b10, confidence=4'h7, one pulse at cycle N.
  - uart_tx is first low in cycle N+2, each bit held 10 cycles.
  - Decoded bytes are 0xA2 then 0x70; tx_busy is high for 200 cycles.
  - Checksum build adds 0xD2 and tx_busy is high for 300 cycles.
- Back-to-back: 3 pulses in consecutive cycles, all gesture=1, confidence=3.
  - fifo_level peaks at 2.
  - Three packets with byte1 = 0x30, 0x31, 0x32 respectively.
  - Exactly 1 idle-high cycle between packets.
- Overflow, FIFO_DEPTH=4: 8 pulses in consecutive cycles while idle.
  - One event is popped immediately, 4 are stored, 3 are dropped: drop_count=3.
  - Exactly 5 packets are emitted.
- Simultaneous push/pop when full: fill the FIFO, then pulse gesture_valid in the exact cycle the FSM pops.
  - fifo_level stays at 4, drop_count unchanged.
- Seq wrap: send 17 events.
  - The 16th packet has seq=15, the 17th has seq=0.
- Reset mid-frame: assert rst for 1 cycle during DATA bit 4 of byte0.
  - uart_tx=1 and tx_busy=0 on the next cycle; fifo_level=0.
  - The next event's packet carries seq=0.
